ws2812_pixel_streamer: RTL

- Upstream stage of the WS2812 bit-timing encoder.
- Accepts 24-bit pixel words over a valid/ready handshake and serialises them MSB-first, one bit per encoder handshake.
- Counts pixels per frame. After NUM_LEDS pixels, holds the line idle for a latch/reset gap so the strip displays the frame.
- Detects upstream underrun mid-frame and aborts the frame cleanly.

---
 rtl/ws2812_pixel_streamer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ws2812_pixel_streamer.sv
// rtl/ws2812_pixel_streamer.sv - serialises 24-bit GRB pixels MSB-first into the WS2812 bit encoder
//
// Accepts one pixel at a time, hands it to the bit encoder one bit per
// strobe/busy handshake, and counts pixels per frame. After NUM_LEDS pixels,
// or when upstream starves mid-frame, it holds the line low for a latch gap.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pix_data/valid/ready    pixel input handshake (bit 23 goes out first)
//   bit_out, bit_strobe     data bit and one-cycle start pulse to the encoder
//   enc_busy                encoder is transmitting the current bit
//   latching                high for the whole latch gap
//   frame_done              one-cycle pulse on the last latch-gap cycle
//   underrun                sticky: a frame was aborted because upstream starved
module ws2812_pixel_streamer #(
   parameter int NUM_LEDS        = 8,
   parameter int RESET_CYCLES    = 16,
   parameter int UNDERRUN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        bit_out,
   output logic        bit_strobe,
   input  logic        enc_busy,
   output logic        latching,
   output logic        frame_done,
   output logic        underrun
);

   localparam int PC_W = $clog2(NUM_LEDS + 1);
   localparam int LC_W = $clog2(RESET_CYCLES + 1);
   localparam int SC_W = $clog2(UNDERRUN_CYCLES + 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_LEDS - 1);
   localparam logic [LC_W-1:0] LC_LAST = LC_W'(RESET_CYCLES - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(UNDERRUN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_HI,
      S_WAIT_LO,
      S_LATCH
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [23:0]       shreg;
   logic [4:0]        bit_cnt;
   logic [PC_W-1:0]   pix_count;
   logic [LC_W-1:0]   latch_cnt;
   logic [SC_W-1:0]   starve_cnt;

   logic accept;
   logic starve_tick;
   logic starve_hit;
   logic send_go;
   logic bit_end;
   logic latch_last;

   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      starve_tick = 1'b0;
      starve_hit  = 1'b0;
      send_go     = 1'b0;
      bit_end     = 1'b0;
      latch_last  = 1'b0;
      case (state)
         S_IDLE: begin
            // A pixel arriving on the cycle the starve limit would trip wins.
            if (pix_valid && pix_ready) begin
               accept     = 1'b1;
               next_state = S_SEND;
            end else if (!pix_valid && (pix_count != '0)) begin
               if (starve_cnt == SC_LAST) begin
                  starve_hit = 1'b1;
                  next_state = S_LATCH;
               end else begin
                  starve_tick = 1'b1;
               end
            end
         end
         S_SEND: begin
            if (!enc_busy) begin
               send_go    = 1'b1;
               next_state = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            // Only the rising acknowledge matters; a low glitch just keeps us here.
            if (enc_busy) begin
               next_state = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!enc_busy) begin
               bit_end = 1'b1;
               if (bit_cnt != 5'd0) begin
                  next_state = S_SEND;
               end else if (pix_count == PC_LAST) begin
                  next_state = S_LATCH;
               end else begin
                  next_state = S_IDLE;
               end
            end
         end
         S_LATCH: begin
            if (latch_cnt == LC_LAST) begin
               latch_last = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         pix_count  <= '0;
         latch_cnt  <= '0;
         starve_cnt <= '0;
         pix_ready  <= 1'b0;
         bit_out    <= 1'b0;
         bit_strobe <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state <= next_state;

         // Registered so it is low while in reset and exactly tracks IDLE after.
         pix_ready  <= (next_state == S_IDLE);

         // Strobe and its data bit are registered together so the encoder
         // sees them in the same cycle.
         bit_strobe <= send_go;
         if (send_go) begin
            bit_out <= shreg[23];
         end else if (next_state == S_LATCH) begin
            bit_out <= 1'b0;
         end

         if (accept) begin
            shreg   <= pix_data;
            bit_cnt <= 5'd23;
         end else if (bit_end && (bit_cnt != 5'd0)) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt - 5'd1;
         end

         if (bit_end && (bit_cnt == 5'd0)) begin
            pix_count <= (pix_count == PC_LAST) ? '0 : pix_count + 1'b1;
         end else if (starve_hit || latch_last) begin
            pix_count <= '0;
         end

         if (accept || starve_hit || latch_last) begin
            starve_cnt <= '0;
         end else if (starve_tick) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         if (state == S_LATCH) begin
            latch_cnt <= latch_last ? '0 : latch_cnt + 1'b1;
         end

         if (starve_hit) begin
            underrun <= 1'b1;
         end
      end
   end

   assign latching   = (state == S_LATCH);
   assign frame_done = latch_last;

endmodule
